multi_phase_broadcast_controller: RTL and testbench

MULTI_PHASE_BROADCAST_CONTROLLER -- requirements
Module: multi_phase_broadcast_controller

---
 rtl/multi_phase_broadcast_controller_if.sv | 45 ++++
 rtl/multi_phase_broadcast_controller.sv | 189 ++++++++++++++++++
 tb/tb_multi_phase_broadcast_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_phase_broadcast_controller_if.sv
// Bus bundle between the broadcast controller and the cell array.
// The master side is the controller; the slave side is the cells plus write-back logic.
interface multi_phase_broadcast_controller_if #(
    parameter int unsigned NUM_CELLS         = 64,
    parameter int unsigned PARTICLE_ID_WIDTH = 7,
    parameter int unsigned NUM_PHASES        = 2,
    parameter int unsigned ITER_CNT_WIDTH    = 16
);
    localparam int unsigned PHASE_WIDTH = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1;

    logic                                   iter_start;
    logic [NUM_CELLS-1:0]                   cell_mask;
    logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0] particle_num;
    logic [NUM_CELLS-1:0]                   back_pressure;
    logic [NUM_CELLS-1:0]                   filter_buffer_empty;
    logic [NUM_CELLS-1:0]                   reading_done;
    logic                                   all_force_wr_issued;
    logic                                   all_ref_wb_issued;

    logic                                   all_reading_done;
    logic                                   all_filter_buffer_empty;
    logic [PARTICLE_ID_WIDTH-1:0]           particle_id;
    logic [PARTICLE_ID_WIDTH-1:0]           ref_id;
    logic [PHASE_WIDTH-1:0]                 phase;
    logic                                   reading_particle_num;
    logic                                   pause_reading;
    logic                                   goto_next_ref;
    logic                                   busy;
    logic                                   iter_done;
    logic [ITER_CNT_WIDTH-1:0]              iter_count;

    modport master (
        input  iter_start, cell_mask, particle_num, back_pressure, filter_buffer_empty,
               reading_done, all_force_wr_issued, all_ref_wb_issued,
        output all_reading_done, all_filter_buffer_empty, particle_id, ref_id, phase,
               reading_particle_num, pause_reading, goto_next_ref, busy, iter_done, iter_count
    );

    modport slave (
        output iter_start, cell_mask, particle_num, back_pressure, filter_buffer_empty,
               reading_done, all_force_wr_issued, all_ref_wb_issued,
        input  all_reading_done, all_filter_buffer_empty, particle_id, ref_id, phase,
               reading_particle_num, pause_reading, goto_next_ref, busy, iter_done, iter_count
    );
endinterface

// File: rtl/multi_phase_broadcast_controller.sv
// Sequences neighbour-id broadcasts over several phases per reference particle and
// steps the reference id until every cell reports its reading is done.
module multi_phase_broadcast_controller #(
    parameter int unsigned NUM_CELLS         = 64,
    parameter int unsigned PARTICLE_ID_WIDTH = 7,
    parameter int unsigned NUM_PHASES        = 2,
    parameter int unsigned START_WAIT_CYCLES = 10,
    parameter int unsigned ITER_CNT_WIDTH    = 16
) (
    input logic clk,
    input logic rst,
    multi_phase_broadcast_controller_if.master bus
);
    localparam int unsigned PHASE_WIDTH = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1;

    localparam logic [PHASE_WIDTH-1:0]       LAST_PHASE = PHASE_WIDTH'(NUM_PHASES - 1);
    localparam logic [7:0]                   WAIT_LAST  = 8'(START_WAIT_CYCLES - 1);
    localparam logic [PARTICLE_ID_WIDTH-1:0] ID_ZERO    = '0;
    localparam logic [PARTICLE_ID_WIDTH-1:0] ID_ONE     = PARTICLE_ID_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStartWait,
        StReadNum,
        StReading,
        StWaitPhase,
        StWaitNextRef
    } state_e;

    state_e                       state_q, state_d;
    logic [7:0]                   wait_cnt_q, wait_cnt_d;
    logic                         ref_advanced_q, ref_advanced_d;
    logic [PARTICLE_ID_WIDTH-1:0] particle_id_q, particle_id_d;
    logic [PARTICLE_ID_WIDTH-1:0] ref_id_q, ref_id_d;
    logic [PHASE_WIDTH-1:0]       phase_q, phase_d;
    logic                         read_num_q, read_num_d;
    logic                         pause_q, pause_d;
    logic                         iter_done_q, iter_done_d;
    logic [ITER_CNT_WIDTH-1:0]    iter_count_q, iter_count_d;

    logic [NUM_CELLS-1:0] cell_bc_done;
    logic                 all_bc_done;
    logic                 any_stall;
    logic                 all_rd_done;
    logic                 all_fb_empty;

    // A masked-off cell is always considered finished; mask and counts are used live.
    for (genvar g = 0; g < int'(NUM_CELLS); g++) begin : gen_cell_done
        assign cell_bc_done[g] = ~bus.cell_mask[g] |
            (particle_id_q > bus.particle_num[g*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH]);
    end

    assign all_bc_done  = &cell_bc_done;
    assign any_stall    = |(bus.back_pressure & bus.cell_mask);
    assign all_rd_done  = &(bus.reading_done | ~bus.cell_mask);
    assign all_fb_empty = &(bus.filter_buffer_empty | ~bus.cell_mask);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            wait_cnt_q     <= '0;
            ref_advanced_q <= 1'b0;
            particle_id_q  <= ID_ZERO;
            ref_id_q       <= ID_ONE;
            phase_q        <= '0;
            read_num_q     <= 1'b0;
            pause_q        <= 1'b1;
            iter_done_q    <= 1'b0;
            iter_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            ref_advanced_q <= ref_advanced_d;
            particle_id_q  <= particle_id_d;
            ref_id_q       <= ref_id_d;
            phase_q        <= phase_d;
            read_num_q     <= read_num_d;
            pause_q        <= pause_d;
            iter_done_q    <= iter_done_d;
            iter_count_q   <= iter_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        ref_advanced_d = ref_advanced_q;
        particle_id_d  = particle_id_q;
        ref_id_d       = ref_id_q;
        phase_d        = phase_q;
        read_num_d     = read_num_q;
        pause_d        = pause_q;
        iter_done_d    = 1'b0;
        iter_count_d   = iter_count_q;

        case (state_q)
            StIdle: begin
                ref_id_d      = ID_ONE;
                phase_d       = '0;
                particle_id_d = ID_ZERO;
                pause_d       = 1'b1;
                read_num_d    = 1'b0;
                if (bus.iter_start) begin
                    state_d    = StStartWait;
                    wait_cnt_d = '0;
                end
            end
            StStartWait: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = StReadNum;
                    read_num_d    = 1'b1;
                    pause_d       = 1'b0;
                    particle_id_d = ID_ZERO;
                end
            end
            StReadNum: begin
                state_d       = StReading;
                particle_id_d = ID_ONE;
                read_num_d    = 1'b0;
                pause_d       = 1'b0;
            end
            StReading: begin
                if (all_bc_done) begin
                    particle_id_d = ID_ONE;
                    pause_d       = 1'b1;
                    if (phase_q < LAST_PHASE) begin
                        state_d = StWaitPhase;
                    end else begin
                        state_d        = StWaitNextRef;
                        ref_advanced_d = 1'b0;
                    end
                end else if (any_stall) begin
                    pause_d = 1'b1;
                end else begin
                    particle_id_d = particle_id_q + 1'b1;
                    pause_d       = 1'b0;
                end
            end
            StWaitPhase: begin
                if (all_fb_empty) begin
                    phase_d = phase_q + 1'b1;
                    pause_d = 1'b0;
                    state_d = StReading;
                end else begin
                    pause_d = 1'b1;
                end
            end
            StWaitNextRef: begin
                if (all_rd_done && bus.all_force_wr_issued) begin
                    state_d        = StIdle;
                    iter_done_d    = 1'b1;
                    iter_count_d   = iter_count_q + 1'b1;
                    ref_id_d       = ID_ONE;
                    phase_d        = '0;
                    particle_id_d  = ID_ZERO;
                    pause_d        = 1'b1;
                    ref_advanced_d = 1'b0;
                end else if (all_rd_done) begin
                    pause_d = 1'b1;
                end else if (all_fb_empty && !ref_advanced_q) begin
                    // Bump the reference only once per drain; write-back gates the restart.
                    ref_id_d       = ref_id_q + 1'b1;
                    ref_advanced_d = 1'b1;
                end else if (ref_advanced_q && bus.all_ref_wb_issued) begin
                    phase_d = '0;
                    pause_d = 1'b0;
                    state_d = StReading;
                end else begin
                    pause_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.all_reading_done        = all_rd_done;
    assign bus.all_filter_buffer_empty = all_fb_empty;
    assign bus.particle_id             = particle_id_q;
    assign bus.ref_id                  = ref_id_q;
    assign bus.phase                   = phase_q;
    assign bus.reading_particle_num    = read_num_q;
    assign bus.pause_reading           = pause_q;
    assign bus.busy                    = (state_q != StIdle);
    assign bus.iter_done               = iter_done_q;
    assign bus.iter_count              = iter_count_q;
    assign bus.goto_next_ref = ((state_q == StWaitPhase) && all_fb_empty) ||
        ((state_q == StWaitNextRef) && !all_rd_done && ref_advanced_q && bus.all_ref_wb_issued);
endmodule

// File: tb/tb_multi_phase_broadcast_controller.sv
// Directed bench: table of combinational aggregate vectors plus hand-written FSM sequences.
module tb_multi_phase_broadcast_controller;
    localparam int unsigned NC = 4;
    localparam int unsigned PW = 7;
    localparam int unsigned NP = 3;
    localparam int unsigned SW = 10;
    localparam int unsigned IW = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    multi_phase_broadcast_controller_if #(
        .NUM_CELLS(NC), .PARTICLE_ID_WIDTH(PW), .NUM_PHASES(NP), .ITER_CNT_WIDTH(IW)
    ) bus ();

    multi_phase_broadcast_controller #(
        .NUM_CELLS(NC), .PARTICLE_ID_WIDTH(PW), .NUM_PHASES(NP),
        .START_WAIT_CYCLES(SW), .ITER_CNT_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        logic [NC-1:0] mask;
        logic [NC-1:0] rd;
        logic [NC-1:0] fbe;
        logic          exp_ard;
        logic          exp_afbe;
    } agg_vec_t;

    agg_vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_iter();
        bus.iter_start = 1'b1;
        step();
        bus.iter_start = 1'b0;
        chk("start_busy", 32'(bus.busy), 1);
        for (int k = 1; k < int'(SW); k++) begin
            step();
            chk("start_wait_rpn", 32'(bus.reading_particle_num), 0);
            chk("start_wait_pause", 32'(bus.pause_reading), 1);
        end
        step();
        chk("read_num_rpn", 32'(bus.reading_particle_num), 1);
        chk("read_num_pid", 32'(bus.particle_id), 0);
        chk("read_num_pause", 32'(bus.pause_reading), 0);
        step();
        chk("reading_rpn", 32'(bus.reading_particle_num), 0);
        chk("reading_pid_first", 32'(bus.particle_id), 1);
        chk("reading_pause", 32'(bus.pause_reading), 0);
    endtask

    // Called on the first READING cycle; leaves the bench one cycle after the exit edge.
    task automatic sweep(input int ph);
        chk("sweep_pid_first", 32'(bus.particle_id), 1);
        chk("sweep_phase", 32'(bus.phase), 32'(ph));
        for (int p = 2; p <= 6; p++) begin
            step();
            chk("sweep_pid", 32'(bus.particle_id), 32'(p));
            chk("sweep_pause", 32'(bus.pause_reading), 0);
        end
        step();
        chk("sweep_exit_pid", 32'(bus.particle_id), 1);
        chk("sweep_exit_pause", 32'(bus.pause_reading), 1);
        chk("sweep_exit_phase", 32'(bus.phase), 32'(ph));
    endtask

    task automatic next_phase();
        chk("wait_phase_goto_idle", 32'(bus.goto_next_ref), 0);
        step();
        chk("wait_phase_hold_pause", 32'(bus.pause_reading), 1);
        chk("wait_phase_hold_pid", 32'(bus.particle_id), 1);
        bus.filter_buffer_empty = '1;
        #1;
        chk("wait_phase_goto", 32'(bus.goto_next_ref), 1);
        step();
        bus.filter_buffer_empty = '0;
        chk("phase_enter_pause", 32'(bus.pause_reading), 0);
    endtask

    initial begin
        vecs[0] = '{mask: 4'hF, rd: 4'hF, fbe: 4'h0, exp_ard: 1'b1, exp_afbe: 1'b0};
        vecs[1] = '{mask: 4'hF, rd: 4'h7, fbe: 4'hF, exp_ard: 1'b0, exp_afbe: 1'b1};
        vecs[2] = '{mask: 4'h0, rd: 4'h0, fbe: 4'h0, exp_ard: 1'b1, exp_afbe: 1'b1};
        vecs[3] = '{mask: 4'h5, rd: 4'h5, fbe: 4'hA, exp_ard: 1'b1, exp_afbe: 1'b0};
        vecs[4] = '{mask: 4'hA, rd: 4'h5, fbe: 4'hA, exp_ard: 1'b0, exp_afbe: 1'b1};
        vecs[5] = '{mask: 4'h8, rd: 4'h8, fbe: 4'h7, exp_ard: 1'b1, exp_afbe: 1'b0};

        rst                     = 1'b0;
        bus.iter_start          = 1'b0;
        bus.cell_mask           = 4'hF;
        bus.particle_num        = {7'd4, 7'd2, 7'd5, 7'd3};
        bus.back_pressure       = '0;
        bus.filter_buffer_empty = '0;
        bus.reading_done        = '0;
        bus.all_force_wr_issued = 1'b0;
        bus.all_ref_wb_issued   = 1'b0;
        step();
        step();

        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ref_id", 32'(bus.ref_id), 1);
        chk("rst_phase", 32'(bus.phase), 0);
        chk("rst_pid", 32'(bus.particle_id), 0);
        chk("rst_pause", 32'(bus.pause_reading), 1);
        chk("rst_rpn", 32'(bus.reading_particle_num), 0);
        chk("rst_iter_done", 32'(bus.iter_done), 0);
        chk("rst_iter_count", 32'(bus.iter_count), 0);
        chk("rst_goto", 32'(bus.goto_next_ref), 0);

        rst = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            bus.cell_mask           = vecs[i].mask;
            bus.reading_done        = vecs[i].rd;
            bus.filter_buffer_empty = vecs[i].fbe;
            #1;
            chk("agg_all_reading_done", 32'(bus.all_reading_done), 32'(vecs[i].exp_ard));
            chk("agg_all_fb_empty", 32'(bus.all_filter_buffer_empty), 32'(vecs[i].exp_afbe));
        end
        bus.cell_mask           = 4'hF;
        bus.reading_done        = '0;
        bus.filter_buffer_empty = '0;
        step();
        chk("idle_stays_idle", 32'(bus.busy), 0);

        // Start timing and three-phase sweep for ref 1.
        start_iter();
        sweep(0);
        next_phase();
        sweep(1);
        next_phase();
        sweep(2);
        chk("wnr_ref_id", 32'(bus.ref_id), 1);
        chk("wnr_goto_before_adv", 32'(bus.goto_next_ref), 0);

        // Reference advance and write-back handshake.
        bus.filter_buffer_empty = '1;
        step();
        bus.filter_buffer_empty = '0;
        chk("ref_adv_id", 32'(bus.ref_id), 2);
        chk("ref_adv_goto_no_wb", 32'(bus.goto_next_ref), 0);
        bus.filter_buffer_empty = '1;
        step();
        bus.filter_buffer_empty = '0;
        chk("ref_adv_once", 32'(bus.ref_id), 2);
        chk("ref_adv_hold_pause", 32'(bus.pause_reading), 1);
        bus.all_ref_wb_issued = 1'b1;
        #1;
        chk("ref_wb_goto", 32'(bus.goto_next_ref), 1);
        step();
        bus.all_ref_wb_issued = 1'b0;
        chk("ref2_phase", 32'(bus.phase), 0);
        chk("ref2_pid", 32'(bus.particle_id), 1);
        chk("ref2_pause", 32'(bus.pause_reading), 0);

        // Back pressure on cell 2, then the same with cell 2 masked off.
        step();
        chk("bp_pre_pid", 32'(bus.particle_id), 2);
        bus.back_pressure = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_frozen_pid", 32'(bus.particle_id), 2);
            chk("bp_pause", 32'(bus.pause_reading), 1);
        end
        bus.back_pressure = '0;
        step();
        chk("bp_release_pid", 32'(bus.particle_id), 3);
        chk("bp_release_pause", 32'(bus.pause_reading), 0);
        bus.cell_mask     = 4'b1011;
        bus.back_pressure = 4'b0100;
        step();
        chk("bp_masked_pid", 32'(bus.particle_id), 4);
        chk("bp_masked_pause", 32'(bus.pause_reading), 0);
        step();
        chk("bp_masked_pid2", 32'(bus.particle_id), 5);
        bus.cell_mask     = 4'hF;
        bus.back_pressure = '0;
        step();
        chk("bp_end_pid", 32'(bus.particle_id), 6);
        step();
        chk("bp_exit_pid", 32'(bus.particle_id), 1);
        chk("bp_exit_pause", 32'(bus.pause_reading), 1);

        // Finish ref 2 and end the iteration.
        next_phase();
        sweep(1);
        next_phase();
        sweep(2);
        bus.reading_done        = '1;
        bus.filter_buffer_empty = '1;
        #1;
        chk("end_all_rd_done", 32'(bus.all_reading_done), 1);
        chk("end_goto", 32'(bus.goto_next_ref), 0);
        step();
        chk("end_hold_ref", 32'(bus.ref_id), 2);
        chk("end_hold_busy", 32'(bus.busy), 1);
        chk("end_hold_done", 32'(bus.iter_done), 0);
        bus.all_force_wr_issued = 1'b1;
        step();
        bus.reading_done        = '0;
        bus.filter_buffer_empty = '0;
        bus.all_force_wr_issued = 1'b0;
        chk("end_iter_done", 32'(bus.iter_done), 1);
        chk("end_busy", 32'(bus.busy), 0);
        chk("end_iter_count", 32'(bus.iter_count), 1);
        chk("end_ref_id", 32'(bus.ref_id), 1);
        chk("end_phase", 32'(bus.phase), 0);
        chk("end_pid", 32'(bus.particle_id), 0);
        chk("end_pause", 32'(bus.pause_reading), 1);
        step();
        chk("end_done_pulse", 32'(bus.iter_done), 0);
        chk("end_idle_count", 32'(bus.iter_count), 1);

        // Mid-operation reset at particle_id 4, phase 1.
        start_iter();
        sweep(0);
        next_phase();
        step();
        step();
        step();
        chk("mid_pre_pid", 32'(bus.particle_id), 4);
        chk("mid_pre_phase", 32'(bus.phase), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_pid", 32'(bus.particle_id), 0);
        chk("mid_rst_phase", 32'(bus.phase), 0);
        chk("mid_rst_ref", 32'(bus.ref_id), 1);
        chk("mid_rst_pause", 32'(bus.pause_reading), 1);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_count", 32'(bus.iter_count), 0);
        step();

        // All cells masked off: READING leaves on its first cycle.
        bus.cell_mask = '0;
        start_iter();
        step();
        chk("zero_mask_pid", 32'(bus.particle_id), 1);
        chk("zero_mask_pause", 32'(bus.pause_reading), 1);
        chk("zero_mask_phase", 32'(bus.phase), 0);
        chk("zero_mask_ard", 32'(bus.all_reading_done), 1);
        chk("zero_mask_goto", 32'(bus.goto_next_ref), 1);
        step();
        chk("zero_mask_phase_adv", 32'(bus.phase), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
